// File: rtl/rom_streamer_if.sv
// rom_streamer_if: control, memory and stream signals of rom_streamer.
//   start/base_addr/len   burst request, sampled by the streamer in IDLE
//   busy/done             burst status
//   mem_addr/mem_data     synchronous-read memory port (data one edge after addr)
//   out_*                 valid/ready word stream, out_last tags the final word
// slave is the streamer side, master is the requester/memory/consumer side.
interface rom_streamer_if #(
    parameter int width     = 64,
    parameter int addr_size = 6
);
    logic                 start;
    logic [addr_size-1:0] base_addr;
    logic [addr_size:0]   len;
    logic                 busy;
    logic                 done;
    logic [addr_size-1:0] mem_addr;
    logic [width-1:0]     mem_data;
    logic [width-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport slave (
        input  start, base_addr, len, mem_data, out_ready,
        output busy, done, mem_addr, out_data, out_valid, out_last
    );

    modport master (
        output start, base_addr, len, mem_data, out_ready,
        input  busy, done, mem_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/rom_streamer.sv
// rom_streamer: reads a burst of len words from base_addr (wrapping modulo depth)
// out of a synchronous-read memory and streams them through a 2-entry FIFO.
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    rom_streamer_if.slave (request, status, memory port, output stream)
module rom_streamer #(
    parameter int width     = 64,
    parameter int depth     = 64,
    parameter int addr_size = $clog2(depth)
) (
    input  logic           clk,
    input  logic           rst_n,
    rom_streamer_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [addr_size-1:0] last_addr = addr_size'(depth - 1);
    localparam logic [addr_size-1:0] addr_one  = addr_size'(1);
    localparam logic [addr_size:0]   cnt_one   = (addr_size + 1)'(1);

    logic [1:0]           state;
    logic [addr_size-1:0] addr;
    logic [addr_size:0]   len_reg;
    logic [addr_size:0]   issue_cnt;
    logic                 inflight;
    logic                 inflight_last;
    logic                 done_r;
    logic [width-1:0]     fifo_data [2];
    logic [1:0]           fifo_last;
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           count;
    logic                 pop;
    logic                 issue;
    logic                 accept;
    logic                 final_pop;

    assign pop       = (count != 2'd0) && bus.out_ready;
    assign accept    = (state == IDLE) && bus.start;
    assign final_pop = (state == RUN) && pop && fifo_last[rd_ptr];
    // A new read may only go out if its word is guaranteed a FIFO slot on return.
    assign issue     = (state == RUN) && (issue_cnt < len_reg) &&
                       (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    // addr tracks (base + issue_cnt) mod depth incrementally, so depth need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            len_reg       <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_r        <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= '0;
        end else begin
            done_r        <= (accept && bus.len == '0) || final_pop;
            inflight      <= issue;
            inflight_last <= issue && (issue_cnt == len_reg - cnt_one);
            if (accept) begin
                state     <= (bus.len == '0) ? FLUSH : RUN;
                addr      <= bus.base_addr;
                len_reg   <= bus.len;
                issue_cnt <= '0;
            end else if (state == FLUSH || final_pop) begin
                state <= IDLE;
            end
            if (issue) begin
                issue_cnt <= issue_cnt + cnt_one;
                addr      <= (addr == last_addr) ? '0 : addr + addr_one;
            end
            if (inflight) begin
                fifo_data[wr_ptr] <= bus.mem_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.done      = done_r;
    assign bus.mem_addr  = (state == RUN) ? addr : '0;
    assign bus.out_valid = count != 2'd0;
    assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_last  = bus.out_valid && fifo_last[rd_ptr];
endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: random and directed bursts checked against a queue-based model of the memory contents.
module tb_rom_streamer;
    localparam int width     = 64;
    localparam int depth     = 64;
    localparam int addr_size = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [width-1:0] rom [depth];
    int               checks = 0;
    int               errors = 0;

    rom_streamer_if #(.width(width), .addr_size(addr_size)) bus();

    rom_streamer #(.width(width), .depth(depth), .addr_size(addr_size)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input bit ramp);
        for (int i = 0; i < depth; i++)
            rom[i] = ramp ? 64'(i) : {$urandom, $urandom};
    endtask

    // Called at a negedge; returns at the negedge where done is expected.
    task automatic run_burst(input int b, input int n, input int mode, input bit inject);
        logic [63:0] q[$];
        bit seen = 0;
        bit fin = 0;
        bit lastx = 0;
        int cyc = 0;
        for (int k = 0; k < n; k++) q.push_back(rom[(b + k) % depth]);
        bus.start     = 1'b1;
        bus.base_addr = addr_size'(b);
        bus.len       = (addr_size + 1)'(n);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_start", bus.busy, 1);
        if (n == 0) begin
            chk("flush_done", bus.done, 1);
            chk("flush_valid", bus.out_valid, 0);
            @(negedge clk);
            chk("flush_busy_end", bus.busy, 0);
            chk("flush_done_end", bus.done, 0);
            chk("flush_valid_end", bus.out_valid, 0);
            return;
        end
        while (!fin) begin
            if (lastx) begin
                chk("done", bus.done, 1);
                chk("busy_end", bus.busy, 0);
                chk("addr_idle", bus.mem_addr, 0);
                fin = 1;
            end else if (cyc >= 2000) begin
                chk("timeout", 64'(q.size()), 0);
                fin = 1;
            end else begin
                chk("done_low", bus.done, 0);
                if (bus.out_valid && q.size() == 0) begin
                    chk("extra_word", bus.out_valid, 0);
                end else if (bus.out_valid) begin
                    if (!seen && mode == 0) chk("latency", 64'(cyc), 2);
                    seen = 1;
                    chk("data", bus.out_data, q[0]);
                    chk("last", bus.out_last, 64'(q.size() == 1));
                end else if (seen && mode == 0) begin
                    chk("bubble", bus.out_valid, 1);
                end
                if (inject) begin
                    bus.start     = (cyc == 2);
                    bus.base_addr = addr_size'(b + 17);
                    bus.len       = 7'd3;
                end
                bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                    lastx = (q.size() == 1);
                    void'(q.pop_front());
                end
                cyc++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int xf;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.out_ready = 1'b0;
        fill_rom(1);
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_last", bus.out_last, 0);
        rst_n = 1'b1;
        run_burst(5, 4, 0, 0);
        run_burst(62, 4, 0, 0);
        run_burst(0, 8, 1, 0);
        run_burst(0, 0, 0, 0);
        run_burst(10, 6, 0, 1);

        bus.start     = 1'b1;
        bus.base_addr = '0;
        bus.len       = 7'd10;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        xf = 0;
        for (int c = 0; c < 50 && xf < 3; c++) begin
            if (bus.out_valid) begin
                chk("pre_rst_data", bus.out_data, 64'(xf));
                xf++;
            end
            if (xf < 3) @(negedge clk);
        end
        chk("pre_rst_words", 64'(xf), 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        chk("mid_rst_last", bus.out_last, 0);
        @(negedge clk);
        @(negedge clk);
        chk("held_rst_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        run_burst(20, 2, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("post_idle_valid", bus.out_valid, 0);
        end

        fill_rom(0);
        for (int t = 0; t < 20; t++)
            run_burst($urandom_range(0, depth - 1), $urandom_range(1, 100), $urandom_range(0, 2), 0);
        run_burst($urandom_range(0, depth - 1), 0, 0, 0);
        run_burst($urandom_range(0, depth - 1), 127, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
